// File: rtl/tpu_pkg.sv
// Shared types for the systolic-array front end: skew FSM states and
// the default activation element.
package tpu_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic [DEFAULT_DATA_W-1:0] act_t;

    typedef enum logic [1:0] {
        SKEW_IDLE   = 2'd0,
        SKEW_STREAM = 2'd1,
        SKEW_DRAIN  = 2'd2
    } skew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of {valid, data}; data is forced to zero when
// not valid so downstream never sees stale values.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/mmu_input_skew.sv
// Feeds the systolic MAC array: diagonally skews each accepted activation
// vector and tracks tile boundaries, draining the skew before tile_done.
module mmu_input_skew
    import tpu_pkg::*;
#(
    parameter int SIZE   = 2,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data   [SIZE],
    output logic [DATA_W-1:0] data_out  [SIZE],
    output logic [SIZE-1:0]   row_valid,
    output logic              run,
    output logic              busy,
    output logic              tile_done
);

    localparam int              CNT_W      = $clog2(SIZE) + 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(SIZE - 1);

    skew_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tile_done_q, tile_done_d;
    logic             accept;

    // Ready depends on state only so upstream can never form a comb loop.
    assign in_ready = (state_q != SKEW_DRAIN);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        case (state_q)
            SKEW_IDLE, SKEW_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = SKEW_DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end else begin
                        state_d = SKEW_STREAM;
                    end
                end
            end
            SKEW_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d     = SKEW_IDLE;
                    tile_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = SKEW_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SKEW_IDLE;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Row r gets r+1 stages, so row r lags row 0 by exactly r cycles.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
            skew_delay_line #(
                .DEPTH  (gi + 1),
                .DATA_W (DATA_W)
            ) u_line (
                .clk     (clk),
                .rst     (rst),
                .valid_i (accept),
                .data_i  (in_data[gi]),
                .valid_o (row_valid[gi]),
                .data_o  (data_out[gi])
            );
        end
    endgenerate

    assign run       = |row_valid;
    assign busy      = (state_q != SKEW_IDLE);
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_mmu_input_skew.sv
// Randomized + directed bench for mmu_input_skew (SIZE=4): stimulus pushes
// expected per-row arrivals and tile_done cycles; a monitor checks every cycle.
module tb_mmu_input_skew;

    localparam int SIZE = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [DW-1:0] in_data  [SIZE];
    logic          in_ready;
    logic [DW-1:0] data_out [SIZE];
    logic [SIZE-1:0] row_valid;
    logic          run, busy, tile_done;

    mmu_input_skew #(.SIZE(SIZE), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .data_out  (data_out),
        .row_valid (row_valid),
        .run       (run),
        .busy      (busy),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } exp_t;

    exp_t rowq [SIZE][$];
    int   done_q[$];
    int   busy_lo = 1, busy_hi = 0;
    int   drain_lo = 1, drain_hi = 0;
    bit   open_tile = 1'b0;

    function automatic bit model_ready(int c);
        return !(c >= drain_lo && c <= drain_hi);
    endfunction

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compare every cycle against the model's expectations.
    always @(negedge clk) begin
        int c;
        logic [SIZE-1:0] ev;
        logic [DW-1:0]   ed;
        c  = cyc;
        ev = '0;
        for (int r = 0; r < SIZE; r++) begin
            ed = '0;
            if (rowq[r].size() > 0 && rowq[r][0].c == c) begin
                ev[r] = 1'b1;
                ed    = rowq[r][0].d;
                void'(rowq[r].pop_front());
            end
            check($sformatf("row_valid[%0d]", r), int'(row_valid[r]), int'(ev[r]));
            check($sformatf("data_out[%0d]", r), int'(data_out[r]), int'(ed));
        end
        check("run", int'(run), int'(|ev));
        check("in_ready", int'(in_ready), int'(model_ready(c)));
        check("busy", int'(busy), int'(c >= busy_lo && c <= busy_hi));
        if (done_q.size() > 0 && done_q[0] == c) begin
            check("tile_done", int'(tile_done), 1);
            void'(done_q.pop_front());
        end else begin
            check("tile_done", int'(tile_done), 0);
        end
    end

    task automatic send(bit v, bit l, logic [SIZE*DW-1:0] dv);
        int   t;
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = v;
        in_last  = l;
        for (int r = 0; r < SIZE; r++) in_data[r] = dv[r*DW +: DW];
        t = cyc;
        if (v && !rst && model_ready(t)) begin
            $display("accept cyc=%0d last=%0b data=%h", t, l, dv);
            for (int r = 0; r < SIZE; r++) begin
                e.c = t + 1 + r;
                e.d = dv[r*DW +: DW];
                rowq[r].push_back(e);
            end
            if (!open_tile) busy_lo = t + 1;
            if (l) begin
                drain_lo  = t + 1;
                drain_hi  = t + SIZE;
                busy_hi   = t + SIZE;
                done_q.push_back(t + SIZE + 1);
                open_tile = 1'b0;
            end else begin
                open_tile = 1'b1;
                busy_hi   = 32'h3fff_ffff;
            end
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < SIZE; r++) rowq[r].delete();
        done_q.delete();
        busy_lo = 1;  busy_hi = 0;
        drain_lo = 1; drain_hi = 0;
        open_tile = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_row_valid", int'(row_valid), 0);
        check("rst_run", int'(run), 0);
        check("rst_tile_done", int'(tile_done), 0);
        check("rst_busy", int'(busy), 0);
        clear_model();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset with live input: nothing may leak through.
        in_valid = 1'b1;
        in_data[0] = 8'd1; in_data[1] = 8'd2; in_data[2] = 8'd3; in_data[3] = 8'd4;
        repeat (3) @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (5) send(0, 0, $urandom);

        // Single-vector tile: skew timing and drain.
        send(1, 1, 32'h44332211);
        repeat (6) send(0, 0, $urandom);

        // Back-to-back 3-vector tile, then overlap in the tile_done cycle.
        send(1, 0, 32'h04030201);
        send(1, 0, 32'h08070605);
        send(1, 1, 32'h0c0b0a09);
        repeat (SIZE) send(1, 0, $urandom);
        send(1, 1, 32'h55555555);
        repeat (6) send(0, 0, $urandom);

        // Bubble mid-tile; the bubble carries in_last without in_valid.
        send(1, 0, 32'ha4a3a2a1);
        send(0, 1, 32'hdeadbeef);
        send(1, 1, 32'hb4b3b2b1);
        repeat (6) send(0, 0, $urandom);

        // Reset two cycles into DRAIN: no tile_done for the aborted tile.
        send(1, 1, 32'hc4c3c2c1);
        repeat (2) send(0, 0, $urandom);
        mid_reset();
        repeat (6) send(0, 0, $urandom);

        // Random traffic.
        repeat (600) send(($urandom % 3) != 0, ($urandom % 5) == 0, $urandom);
        send(1, 1, $urandom);
        repeat (SIZE + 4) send(0, 0, $urandom);

        check("pending_done", done_q.size(), 0);
        for (int r = 0; r < SIZE; r++) check($sformatf("pending_row%0d", r), rowq[r].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
